// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet sequencer: instruction-word bit map,
// idle word, latched tile configuration and FSM state encoding.
package corelet_ctrl_pkg;

  localparam int unsigned INST_W = 35;
  localparam int unsigned ADDR_W = 11;

  // Instruction word bit positions
  localparam int unsigned MAC_KLOAD = 0;
  localparam int unsigned MAC_EXEC  = 1;
  localparam int unsigned L0_WR     = 2;
  localparam int unsigned L0_RD     = 3;
  localparam int unsigned IFIFO_WR  = 4;
  localparam int unsigned IFIFO_RD  = 5;
  localparam int unsigned OFIFO_RD  = 6;
  localparam int unsigned XMEM_LSB  = 7;
  localparam int unsigned XMEM_MSB  = 17;
  localparam int unsigned WEN_XMEM  = 18;
  localparam int unsigned CEN_XMEM  = 19;
  localparam int unsigned PMEM_LSB  = 20;
  localparam int unsigned PMEM_MSB  = 30;
  localparam int unsigned WEN_PMEM  = 31;
  localparam int unsigned CEN_PMEM  = 32;
  localparam int unsigned SFP_ACC   = 33;
  localparam int unsigned MODE      = 34;

  // Both SRAMs deselected and write-disabled (active-low), everything else off
  localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

  // Tile parameters captured when start is accepted
  typedef struct packed {
    logic [ADDR_W-1:0] num_act;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] p_base;
  } tile_cfg_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_FETCH,
    ST_W_LOAD,
    ST_W_DRAIN,
    ST_A_FETCH,
    ST_EXEC,
    ST_E_DRAIN,
    ST_P_WRITE,
    ST_DONE
  } state_e;

  // Bits needed to hold max_v + 1
  function automatic int unsigned cnt_width(int unsigned max_v);
    return $clog2(max_v + 2);
  endfunction

endpackage

// File: rtl/corelet_ctrl_if.sv
// Host <-> sequencer bundle.
//   start/num_act/w_base/a_base/p_base : tile request from the host
//   inst                               : 35-bit corelet/SRAM instruction word
//   busy/done                          : tile status
interface corelet_ctrl_if #(
  parameter int unsigned addr_bw = 11
);
  import corelet_ctrl_pkg::*;

  logic               start;
  logic [addr_bw-1:0] num_act;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] a_base;
  logic [addr_bw-1:0] p_base;
  logic [INST_W-1:0]  inst;
  logic               busy;
  logic               done;

  modport master (
    output start, num_act, w_base, a_base, p_base,
    input  inst, busy, done
  );

  modport slave (
    input  start, num_act, w_base, a_base, p_base,
    output inst, busy, done
  );

endinterface

// File: rtl/corelet_ctrl_phase_counter.sv
// Loadable down-counter shared by all sequencer phases.
//   clk, reset  : clock, async active-high reset (count clears to 0)
//   load        : load load_val this cycle
//   load_val    : phase length minus one
//   cnt         : current count, holds at 0
//   tc_c        : terminal count (cnt == 0), combinational
module phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  // Count register: load wins, otherwise decrement down to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Weight-stationary tile sequencer: fetches a kernel into L0, loads it into
// the MAC array, streams activations, then drains OFIFO results to pmem.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of corelet_ctrl_if (start + tile config in,
//                registered inst/busy/done out)
module corelet_ctrl
  import corelet_ctrl_pkg::*;
#(
  parameter int unsigned row       = 8,
  parameter int unsigned col       = 8,
  parameter int unsigned bw        = 4,
  parameter int unsigned addr_bw   = 11,
  parameter int unsigned drain_cyc = row + col
) (
  input logic           clk,
  input logic           reset,
  corelet_ctrl_if.slave bus
);

  localparam int unsigned ADDR_MAX = (1 << addr_bw) - 1;
  localparam int unsigned MAX_A    = (col > ADDR_MAX) ? col : ADDR_MAX;
  localparam int unsigned MAX_LEN  = (drain_cyc > MAX_A) ? drain_cyc : MAX_A;
  localparam int unsigned CNT_W    = cnt_width(MAX_LEN);

  localparam logic [CNT_W-1:0] COL_C    = CNT_W'(col);
  localparam logic [CNT_W-1:0] COL_M1   = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'(drain_cyc - 1);

  // The instruction-word address fields are fixed at ADDR_W bits
  if (addr_bw != ADDR_W || col == 0 || row == 0 || bw == 0 || drain_cyc == 0) begin : g_bad_param
    $error("corelet_ctrl: unsupported parameter set");
  end

  state_e            state_q, state_d;
  tile_cfg_t         cfg_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  load_val;
  logic              load;
  logic              tc_c;
  logic [CNT_W-1:0]  num_c;
  logic [INST_W-1:0] inst_d, inst_q;
  logic              done_d, done_q, busy_q;

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .tc_c     (tc_c)
  );

  assign num_c = CNT_W'(cfg_q.num_act);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, phase-counter control and next instruction word.
  // Fetch phases run one cycle longer than the read count so the l0_wr strobe
  // can trail each xmem read by the SRAM's one-cycle read latency.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    inst_d   = IDLE_INST;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_W_FETCH;
          load     = 1'b1;
          load_val = COL_C;
        end
      end
      ST_W_FETCH: begin
        if (!tc_c) begin
          inst_d[CEN_XMEM]          = 1'b0;
          inst_d[XMEM_MSB:XMEM_LSB] = cfg_q.w_base + ADDR_W'(COL_C - cnt);
        end
        if (cnt != COL_C) inst_d[L0_WR] = 1'b1;
        if (tc_c) begin
          state_d  = ST_W_LOAD;
          load     = 1'b1;
          load_val = COL_M1;
        end
      end
      ST_W_LOAD: begin
        inst_d[L0_RD]     = 1'b1;
        inst_d[MAC_KLOAD] = 1'b1;
        if (tc_c) begin
          state_d  = ST_W_DRAIN;
          load     = 1'b1;
          load_val = DRAIN_M1;
        end
      end
      ST_W_DRAIN: begin
        if (tc_c) begin
          if (num_c == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_A_FETCH;
            load     = 1'b1;
            load_val = num_c;
          end
        end
      end
      ST_A_FETCH: begin
        if (!tc_c) begin
          inst_d[CEN_XMEM]          = 1'b0;
          inst_d[XMEM_MSB:XMEM_LSB] = cfg_q.a_base + ADDR_W'(num_c - cnt);
        end
        if (cnt != num_c) inst_d[L0_WR] = 1'b1;
        if (tc_c) begin
          state_d  = ST_EXEC;
          load     = 1'b1;
          load_val = num_c - CNT_W'(1);
        end
      end
      ST_EXEC: begin
        inst_d[L0_RD]    = 1'b1;
        inst_d[MAC_EXEC] = 1'b1;
        if (tc_c) begin
          state_d  = ST_E_DRAIN;
          load     = 1'b1;
          load_val = DRAIN_M1;
        end
      end
      ST_E_DRAIN: begin
        if (tc_c) begin
          state_d  = ST_P_WRITE;
          load     = 1'b1;
          load_val = num_c;
        end
      end
      ST_P_WRITE: begin
        // pmem write trails the OFIFO read by one cycle
        if (!tc_c) inst_d[OFIFO_RD] = 1'b1;
        if (cnt != num_c) begin
          inst_d[CEN_PMEM]          = 1'b0;
          inst_d[WEN_PMEM]          = 1'b0;
          inst_d[PMEM_MSB:PMEM_LSB] = cfg_q.p_base + ADDR_W'(num_c - cnt - CNT_W'(1));
        end
        if (tc_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Input FIFO, SFP accumulate and OS mode are never used by this sequencer
    inst_d[IFIFO_WR] = 1'b0;
    inst_d[IFIFO_RD] = 1'b0;
    inst_d[SFP_ACC]  = 1'b0;
    inst_d[MODE]     = 1'b0;
  end

  // Tile configuration capture on accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q <= '0;
    end else if (state_q == ST_IDLE && bus.start) begin
      cfg_q <= '{num_act: bus.num_act, w_base: bus.w_base,
                 a_base: bus.a_base, p_base: bus.p_base};
    end
  end

  // Registered outputs; busy tracks the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= IDLE_INST;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      done_q <= done_d;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: each accepted tile pushes its full
// expected per-cycle {inst, busy, done} trace and done latency; a monitor
// pops and compares every cycle.
module tb_corelet_ctrl;

  localparam int COL   = 8;
  localparam int DRAIN = 16;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [36:0] exp_q[$];
  int          lat_q[$];
  int          start_q[$];

  corelet_ctrl_if #(.addr_bw(11)) cif ();

  corelet_ctrl #(.row(8), .col(COL), .bw(4), .addr_bw(11), .drain_cyc(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  function automatic int exp_lat(input int na);
    return 1 + (COL + 1) + COL + DRAIN + ((na > 0) ? (3 * na + 2 + DRAIN) : 0) + 1;
  endfunction

  // Reference model: per-state-cycle instruction words built from the tile rules
  task automatic push_tile(input int na, input int wb, input int ab, input int pb, input int lat);
    logic [34:0] s[$];
    logic [34:0] w;
    int L;
    s.push_back(IDLE_W);
    for (int k = 0; k <= COL; k++) begin
      w = IDLE_W;
      if (k < COL) begin w[19] = 1'b0; w[17:7] = 11'((wb + k) % 2048); end
      if (k >= 1) w[2] = 1'b1;
      s.push_back(w);
    end
    for (int k = 0; k < COL; k++) begin
      w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1; s.push_back(w);
    end
    for (int k = 0; k < DRAIN; k++) s.push_back(IDLE_W);
    if (na > 0) begin
      for (int i = 0; i <= na; i++) begin
        w = IDLE_W;
        if (i < na) begin w[19] = 1'b0; w[17:7] = 11'((ab + i) % 2048); end
        if (i >= 1) w[2] = 1'b1;
        s.push_back(w);
      end
      for (int i = 0; i < na; i++) begin
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1; s.push_back(w);
      end
      for (int k = 0; k < DRAIN; k++) s.push_back(IDLE_W);
      for (int j = 0; j <= na; j++) begin
        w = IDLE_W;
        if (j < na) w[6] = 1'b1;
        if (j >= 1) begin w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'((pb + j - 1) % 2048); end
        s.push_back(w);
      end
    end
    s.push_back(IDLE_W);
    L = s.size();
    // outputs are registered: inst shows the previous state's word
    exp_q.push_back({IDLE_W, 2'b00});
    for (int m = 1; m <= L; m++) exp_q.push_back({s[m-1], (m < L), (m == L)});
    lat_q.push_back(lat);
    start_q.push_back(cyc);
  endtask

  task automatic rand_inputs();
    cif.num_act = 11'($urandom_range(0, 2047));
    cif.w_base  = 11'($urandom_range(0, 2047));
    cif.a_base  = 11'($urandom_range(0, 2047));
    cif.p_base  = 11'($urandom_range(0, 2047));
  endtask

  // Called at posedge+1 with the DUT idle
  task automatic start_tile(input int na, input int wb, input int ab, input int pb, input int lat);
    cif.num_act = 11'(na);
    cif.w_base  = 11'(wb);
    cif.a_base  = 11'(ab);
    cif.p_base  = 11'(pb);
    cif.start   = 1'b1;
    push_tile(na, wb, ab, pb, lat);
    @(posedge clk); #1;
    cif.start = 1'b0;
    rand_inputs();
  endtask

  task automatic wait_idle(input bit stray);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (stray && exp_q.size() > 3 && $urandom_range(0, 9) == 0) begin
        cif.start = 1'b1;
        rand_inputs();
      end else begin
        cif.start = 1'b0;
      end
    end
    cif.start = 1'b0;
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: one trace comparison per cycle, latency check on each done
  initial forever begin
    logic [36:0] e;
    int lat, st;
    @(negedge clk);
    if (!reset) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = {IDLE_W, 2'b00};
      check("trace", 64'({cif.inst, cif.busy, cif.done}), 64'(e));
      if (cif.done) begin
        if (lat_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          lat = lat_q.pop_front();
          st  = start_q.pop_front();
          check("done_latency", 64'(cyc - st), 64'(lat));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cif.start = 1'b0;
    cif.num_act = '0; cif.w_base = '0; cif.a_base = '0; cif.p_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inst", 64'(cif.inst), 64'(IDLE_W));
    check("reset_busy", 64'(cif.busy), 64'd0);
    check("reset_done", 64'(cif.done), 64'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Basic tile, empty tile, address wrap
    start_tile(4, 0, 16, 100, 65);    wait_idle(1'b0);
    start_tile(0, 0, 16, 100, 35);    wait_idle(1'b0);
    start_tile(4, 5, 2046, 2047, 65); wait_idle(1'b0);

    // Stray start during EXEC is ignored
    start_tile(4, 0, 16, 100, 65);
    repeat (39) @(posedge clk);
    #1;
    cif.start = 1'b1;
    rand_inputs();
    @(posedge clk); #1;
    cif.start = 1'b0;
    wait_idle(1'b0);

    // Reset during EXEC aborts immediately; next tile replays from the start
    start_tile(4, 0, 16, 100, 65);
    repeat (39) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_inst", 64'(cif.inst), 64'(IDLE_W));
    check("abort_busy", 64'(cif.busy), 64'd0);
    check("abort_done", 64'(cif.done), 64'd0);
    exp_q.delete(); lat_q.delete(); start_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_tile(4, 0, 16, 100, 65); wait_idle(1'b0);

    // Randomized tiles with stray starts while busy
    for (int t = 0; t < 10; t++) begin
      int na, wb, ab, pb;
      na = int'($urandom_range(0, 6));
      wb = int'($urandom_range(0, 2047));
      ab = int'($urandom_range(0, 2047));
      pb = int'($urandom_range(0, 2047));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start_tile(na, wb, ab, pb, exp_lat(na));
      wait_idle(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
